rr_vc_allocator: RTL and testbench
==================================

RR_VC_ALLOCATOR -- requirements
Module: rr_vc_allocator

Interface
REQ-001 Parameter PORT_NUM, default 5, number of router ports (upstream = downstream count).
REQ-002 Parameter VC_NUM, default 2, virtual channels per port.
REQ-003 Parameter CNT_W, default 16, width of per-port grant counters (perf build only).
REQ-004 clk  input  1  clock.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 vc_request_i  input  PORT_NUM*VC_NUM  upstream VC [p][v] requests a downstream VC.
REQ-007 out_port_i  input  PORT_NUM*VC_NUM*PORT_SIZE  downstream port targeted by upstream VC [p][v].
REQ-008 idle_downstream_vc_i  input  PORT_NUM*VC_NUM  downstream VC [p][v] drained, releasable.
REQ-009 vc_valid_o  output  PORT_NUM*VC_NUM  grant to upstream VC [p][v] this cycle.
REQ-010 vc_new_o  output  PORT_NUM*VC_NUM*VC_SIZE  allocated downstream VC index; don't-care when vc_valid_o low.
REQ-011 grant_cnt_o  output  PORT_NUM*CNT_W  grants per downstream port (present only with VC_ALLOC_PERF_EN).

Function
REQ-012 State: avail[PORT_NUM][VC_NUM] availability bits; in_ptr[PORT_NUM] (VC_SIZE) per-upstream-port RR pointer; out_ptr[PORT_NUM] (PORT_SIZE) per-downstream-port RR pointer; sel_ptr[PORT_NUM] (VC_SIZE) per-downstream-port VC-selection pointer.
REQ-013 Eligible request: vc_request_i[p][v] AND any avail bit set at out_port_i[p][v].
REQ-014 Stage 1: each upstream port picks one eligible VC, RR starting at in_ptr[p].
REQ-015 Stage 2: each downstream port picks one stage-1 winner targeting it, RR starting at out_ptr[d].
REQ-016 Grant is combinational, same cycle: vc_valid_o high for stage-2 winners only; at most one grant per upstream port and per downstream port per cycle.
REQ-017 vc_new_o = first d-port VC with avail set, searching from sel_ptr[d] with wrap-around modulo VC_NUM.
REQ-018 On grant at rising clk: avail[d][vc_new] cleared; sel_ptr[d] = (vc_new+1) mod VC_NUM; out_ptr[d] = (winning port+1) mod PORT_NUM; in_ptr[p] = (granted VC+1) mod VC_NUM.
REQ-019 Pointers without a grant hold; losing stage-1 winners do not advance in_ptr.
REQ-020 Release: avail[d][v] set at rising clk when avail clear and idle_downstream_vc_i[d][v] high; idle on an already-available VC ignored.
REQ-021 Release takes effect next cycle; a VC released in cycle n is grantable in cycle n+1, never n.
REQ-022 Allocation and release of distinct VCs of one port in the same cycle both apply.
REQ-023 Port with all VCs unavailable: requests targeting it not eligible, no pointer movement.
REQ-024 Non-power-of-two VC_NUM/PORT_NUM: pointer wrap to 0 after max index, never out of range.

Reset
REQ-025 rst asserted: avail all 1; all pointers 0; grant_cnt_o 0; vc_valid_o forced 0 while rst high.
REQ-026 rst mid-operation discards all allocations immediately; first grant possible in first cycle after deassertion.

Configuration
REQ-027 Macro VC_ALLOC_PERF_EN defined: grant_cnt_o present, counter[d] increments by 1 per grant to port d, saturates at 2^CNT_W-1.
REQ-028 Macro VC_ALLOC_PERF_EN undefined: grant_cnt_o port and counters absent; all other behaviour identical.

Structure
REQ-029 PORT_NUM, VC_NUM, PORT_SIZE, VC_SIZE, port_t live in shared noc_params package; CNT_W local parameter.
REQ-030 One sub-module rr_arbiter (parametrised width N, request vector, pointer in, one-hot grant out), instantiated PORT_NUM times per stage.

Verification (PORT_NUM=5, VC_NUM=2)
REQ-031 Reset then [0][0] requests port 2 -> same cycle vc_valid_o[0][0]=1, vc_new=0; next cycle avail[2]=2'b10.
REQ-032 Next grant to port 2 from [1][0] -> vc_new=1 (sel_ptr advanced); third request to port 2 -> no grant until idle_downstream_vc_i[2][0] pulses, then grant vc_new=0 in following cycle.
REQ-033 Upstream ports 0,1,3 all request port 4 for 3 cycles with releases each cycle -> grants in order 0,1,3.
REQ-034 [0][0] and [0][1] both request different free ports continuously -> grants alternate VC0, VC1, VC0.
REQ-035 Same-cycle grant of [4][0] and idle pulse on other VC of its port -> both applied, avail reflects both next cycle.
REQ-036 Perf build: 70000 grants to port 1 -> grant_cnt_o[1]=65535 and holds.

Source files
------------

// File: rtl/noc_params.sv
// -----------------------------------------------------------------------------
// noc_params
// Shared NoC configuration for the router slice: default port and VC counts,
// the index widths derived from them, the matching index types, and two small
// helpers. The first computes an index width that stays at least one bit wide.
// The second advances a round-robin pointer with wrap-around that works for
// counts that are not a power of two.
// -----------------------------------------------------------------------------
package noc_params;

    // Index width for n items. Returns 1 when n <= 1 so vectors never collapse to zero width.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int PORT_NUM  = 5;
    localparam int VC_NUM    = 2;
    localparam int PORT_SIZE = idx_width(PORT_NUM);
    localparam int VC_SIZE   = idx_width(VC_NUM);

    typedef logic [PORT_SIZE-1:0] port_t;
    typedef logic [VC_SIZE-1:0]   vc_t;

    // (idx + 1) mod n, written as a compare so it never leaves [0, n-1].
    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_vc_allocator_if.sv
// -----------------------------------------------------------------------------
// rr_vc_allocator_if
// Bundle between the upstream input units and the VC allocator. Every field is
// a flat vector. Upstream VC [p][v] uses flat index p*VC_NUM+v.
//   vc_request_i          upstream VC [p][v] requests a downstream VC
//   out_port_i            downstream port targeted by [p][v] (PORT_SIZE bits each)
//   idle_downstream_vc_i  downstream VC [d][v] drained and releasable
//   vc_valid_o            grant to upstream VC [p][v] in this cycle
//   vc_new_o              allocated downstream VC index (VC_SIZE bits each)
//   grant_cnt_o           per-downstream-port grant counters (CNT_W bits each),
//                         present only when VC_ALLOC_PERF_EN is defined
// Modports: master = requester side, slave = allocator.
// -----------------------------------------------------------------------------
interface rr_vc_allocator_if #(
    parameter int PORT_NUM = noc_params::PORT_NUM,
    parameter int VC_NUM   = noc_params::VC_NUM
`ifdef VC_ALLOC_PERF_EN
    , parameter int CNT_W  = 16
`endif
);
    localparam int PORT_SIZE = noc_params::idx_width(PORT_NUM);
    localparam int VC_SIZE   = noc_params::idx_width(VC_NUM);

    logic [PORT_NUM*VC_NUM-1:0]           vc_request_i;
    logic [PORT_NUM*VC_NUM*PORT_SIZE-1:0] out_port_i;
    logic [PORT_NUM*VC_NUM-1:0]           idle_downstream_vc_i;
    logic [PORT_NUM*VC_NUM-1:0]           vc_valid_o;
    logic [PORT_NUM*VC_NUM*VC_SIZE-1:0]   vc_new_o;
`ifdef VC_ALLOC_PERF_EN
    logic [PORT_NUM*CNT_W-1:0]            grant_cnt_o;
`endif

    modport master (
        output vc_request_i, out_port_i, idle_downstream_vc_i,
`ifdef VC_ALLOC_PERF_EN
        input  grant_cnt_o,
`endif
        input  vc_valid_o, vc_new_o
    );

    modport slave (
        input  vc_request_i, out_port_i, idle_downstream_vc_i,
`ifdef VC_ALLOC_PERF_EN
        output grant_cnt_o,
`endif
        output vc_valid_o, vc_new_o
    );

endinterface

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin pick among N requesters. The search starts at
// ptr_i and wraps modulo N. The first active request wins.
//   req_i  request vector
//   ptr_i  search start index (values >= N are treated as 0)
//   gnt_o  one-hot grant, all zero when there is no request
// The caller owns the pointer, so it can choose when the pointer advances.
// -----------------------------------------------------------------------------
module rr_arbiter #(
    parameter  int N  = 4,
    localparam int PW = noc_params::idx_width(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o
);

    always_comb begin
        int   start;
        int   idx;
        logic found;
        // NOTE: every variable written here gets a value before any branch, so
        // no path leaves it unassigned and no latch is inferred.
        gnt_o = '0;
        found = 1'b0;
        idx   = 0;
        start = (int'(ptr_i) < N) ? int'(ptr_i) : 0;
        for (int k = 0; k < N; k++) begin
            idx = start + k;
            if (idx >= N) idx = idx - N;
            if (!found && req_i[idx]) begin
                gnt_o[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_vc_allocator.sv
// -----------------------------------------------------------------------------
// rr_vc_allocator
// Separable two-stage round-robin virtual-channel allocator.
//   Stage 1: each upstream port picks one eligible VC, starting at in_ptr[p].
//   Stage 2: each downstream port picks one stage-1 winner that targets it,
//            starting at out_ptr[d].
// A winner receives the first available VC of its downstream port, searching
// from sel_ptr[d]. The grant is combinational and appears in the same cycle.
// On the clock edge the allocated VC is marked busy and the pointers that took
// part in the grant advance. Drained VCs (idle_downstream_vc_i) become
// available one cycle after they are reported.
//
// Ports
//   clk  clock
//   rst  asynchronous active-high reset
//   bus  rr_vc_allocator_if.slave (requests, targets, idle flags, grants)
//
// Build option: define VC_ALLOC_PERF_EN to add per-downstream-port saturating
// grant counters (CNT_W bits each) on bus.grant_cnt_o.
// -----------------------------------------------------------------------------
module rr_vc_allocator #(
    parameter int PORT_NUM = noc_params::PORT_NUM,
    parameter int VC_NUM   = noc_params::VC_NUM
`ifdef VC_ALLOC_PERF_EN
    , parameter int CNT_W  = 16
`endif
) (
    input  logic              clk,
    input  logic              rst,
    rr_vc_allocator_if.slave  bus
);

    localparam int PORT_SIZE = noc_params::idx_width(PORT_NUM);
    localparam int VC_SIZE   = noc_params::idx_width(VC_NUM);

    typedef logic [PORT_SIZE-1:0] pidx_t;
    typedef logic [VC_SIZE-1:0]   vidx_t;

    // ---------------------------------------------------------------- state
    logic [VC_NUM-1:0] avail_q   [PORT_NUM];
    logic [VC_NUM-1:0] avail_d   [PORT_NUM];
    vidx_t             in_ptr_q  [PORT_NUM];
    vidx_t             in_ptr_d  [PORT_NUM];
    pidx_t             out_ptr_q [PORT_NUM];
    pidx_t             out_ptr_d [PORT_NUM];
    vidx_t             sel_ptr_q [PORT_NUM];
    vidx_t             sel_ptr_d [PORT_NUM];

    // ------------------------------------------------------ request decode
    pidx_t             tgt       [PORT_NUM][VC_NUM];
    logic              tgt_ok    [PORT_NUM][VC_NUM];
    logic [VC_NUM-1:0] elig      [PORT_NUM];
    logic [PORT_NUM-1:0] port_free;

    always_comb begin
        for (int d = 0; d < PORT_NUM; d++) port_free[d] = |avail_q[d];
    end

    // A request is eligible only if its target has at least one free VC.
    // Out-of-range targets are never eligible.
    always_comb begin
        for (int p = 0; p < PORT_NUM; p++) begin
            elig[p] = '0;
            for (int v = 0; v < VC_NUM; v++) begin
                tgt[p][v]    = bus.out_port_i[(p*VC_NUM+v)*PORT_SIZE +: PORT_SIZE];
                tgt_ok[p][v] = (int'(tgt[p][v]) < PORT_NUM);
                if (tgt_ok[p][v])
                    elig[p][v] = bus.vc_request_i[p*VC_NUM+v] && port_free[tgt[p][v]];
            end
        end
    end

    // ------------------------------------------------------------- stage 1
    logic [VC_NUM-1:0] s1_gnt   [PORT_NUM];
    vidx_t             s1_vc    [PORT_NUM];
    logic              s1_valid [PORT_NUM];
    pidx_t             s1_tgt   [PORT_NUM];

    for (genvar p = 0; p < PORT_NUM; p++) begin : g_stage1
        rr_arbiter #(.N(VC_NUM)) u_arb (
            .req_i (elig[p]),
            .ptr_i (in_ptr_q[p]),
            .gnt_o (s1_gnt[p])
        );
    end

    always_comb begin
        for (int p = 0; p < PORT_NUM; p++) begin
            s1_vc[p] = '0;
            for (int v = 0; v < VC_NUM; v++)
                if (s1_gnt[p][v]) s1_vc[p] = vidx_t'(v);
            s1_valid[p] = |s1_gnt[p];
            s1_tgt[p]   = tgt[p][s1_vc[p]];
        end
    end

    // ------------------------------------------------------------- stage 2
    logic [PORT_NUM-1:0] s2_req  [PORT_NUM];
    logic [PORT_NUM-1:0] s2_gnt  [PORT_NUM];
    pidx_t               s2_win  [PORT_NUM];
    logic [PORT_NUM-1:0] d_grant;
    logic [PORT_NUM-1:0] up_grant;

    always_comb begin
        for (int d = 0; d < PORT_NUM; d++)
            for (int p = 0; p < PORT_NUM; p++)
                s2_req[d][p] = s1_valid[p] && (int'(s1_tgt[p]) == d);
    end

    for (genvar d = 0; d < PORT_NUM; d++) begin : g_stage2
        rr_arbiter #(.N(PORT_NUM)) u_arb (
            .req_i (s2_req[d]),
            .ptr_i (out_ptr_q[d]),
            .gnt_o (s2_gnt[d])
        );
    end

    always_comb begin
        up_grant = '0;
        for (int d = 0; d < PORT_NUM; d++) begin
            s2_win[d]  = '0;
            d_grant[d] = |s2_gnt[d];
            for (int p = 0; p < PORT_NUM; p++) begin
                if (s2_gnt[d][p]) begin
                    s2_win[d]   = pidx_t'(p);
                    up_grant[p] = 1'b1;
                end
            end
        end
    end

    // ---------------------------------------------- downstream VC selection
    logic [VC_NUM-1:0] sel_gnt [PORT_NUM];
    vidx_t             sel_vc  [PORT_NUM];

    for (genvar d = 0; d < PORT_NUM; d++) begin : g_select
        rr_arbiter #(.N(VC_NUM)) u_arb (
            .req_i (avail_q[d]),
            .ptr_i (sel_ptr_q[d]),
            .gnt_o (sel_gnt[d])
        );
    end

    always_comb begin
        for (int d = 0; d < PORT_NUM; d++) begin
            sel_vc[d] = '0;
            for (int v = 0; v < VC_NUM; v++)
                if (sel_gnt[d][v]) sel_vc[d] = vidx_t'(v);
        end
    end

    // --------------------------------------------------------------- outputs
    // Grants are masked while rst is high so nothing leaks out during reset.
    always_comb begin
        bus.vc_valid_o = '0;
        bus.vc_new_o   = '0;
        for (int p = 0; p < PORT_NUM; p++) begin
            for (int v = 0; v < VC_NUM; v++) begin
                bus.vc_valid_o[p*VC_NUM+v] = !rst && up_grant[p] && s1_gnt[p][v];
                if (tgt_ok[p][v])
                    bus.vc_new_o[(p*VC_NUM+v)*VC_SIZE +: VC_SIZE] = sel_vc[tgt[p][v]];
            end
        end
    end

    // ------------------------------------------------------------ next state
    // A grant only ever takes an available VC, and a release only ever sets a
    // busy one. An allocation and a release in the same cycle therefore touch
    // distinct bits, and both take effect.
    always_comb begin
        avail_d   = avail_q;
        in_ptr_d  = in_ptr_q;
        out_ptr_d = out_ptr_q;
        sel_ptr_d = sel_ptr_q;
        for (int d = 0; d < PORT_NUM; d++) begin
            if (d_grant[d]) begin
                avail_d[d][sel_vc[d]] = 1'b0;
                sel_ptr_d[d] = vidx_t'(noc_params::wrap_inc(int'(sel_vc[d]), VC_NUM));
                out_ptr_d[d] = pidx_t'(noc_params::wrap_inc(int'(s2_win[d]), PORT_NUM));
            end
            for (int v = 0; v < VC_NUM; v++)
                if (!avail_q[d][v] && bus.idle_downstream_vc_i[d*VC_NUM+v])
                    avail_d[d][v] = 1'b1;
        end
        for (int p = 0; p < PORT_NUM; p++)
            if (up_grant[p])
                in_ptr_d[p] = vidx_t'(noc_params::wrap_inc(int'(s1_vc[p]), VC_NUM));
    end

    // NOTE: state registers use non-blocking assignments so that every flop
    // samples the values from before the edge, whatever the evaluation order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the availability array is made of flops, not RAM. Every
            // entry must start as free, so each one is reset explicitly.
            for (int d = 0; d < PORT_NUM; d++) begin
                avail_q[d]   <= '1;
                in_ptr_q[d]  <= '0;
                out_ptr_q[d] <= '0;
                sel_ptr_q[d] <= '0;
            end
        end else begin
            avail_q   <= avail_d;
            in_ptr_q  <= in_ptr_d;
            out_ptr_q <= out_ptr_d;
            sel_ptr_q <= sel_ptr_d;
        end
    end

`ifdef VC_ALLOC_PERF_EN
    // ------------------------------------------------ grant counters (perf)
    logic [CNT_W-1:0] cnt_q [PORT_NUM];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int d = 0; d < PORT_NUM; d++) cnt_q[d] <= '0;
        end else begin
            for (int d = 0; d < PORT_NUM; d++)
                if (d_grant[d] && (cnt_q[d] != {CNT_W{1'b1}}))
                    cnt_q[d] <= cnt_q[d] + CNT_W'(1);
        end
    end

    always_comb begin
        bus.grant_cnt_o = '0;
        for (int d = 0; d < PORT_NUM; d++)
            bus.grant_cnt_o[d*CNT_W +: CNT_W] = cnt_q[d];
    end
`endif

endmodule

// File: tb/tb_rr_vc_allocator.sv
// -----------------------------------------------------------------------------
// tb_rr_vc_allocator
// Self-checking bench for rr_vc_allocator with PORT_NUM=5 and VC_NUM=2.
// A reference model tracks free VCs and the three pointer families as plain
// integer arrays. Each cycle it derives the expected grants from the
// allocation rules. Directed scenarios come first, then randomized traffic
// with occasional mid-run resets. When VC_ALLOC_PERF_EN is defined, the bench
// also checks the grant counters and their saturation.
// -----------------------------------------------------------------------------
module tb_rr_vc_allocator;

    localparam int PN = 5;
    localparam int VN = 2;
    localparam int PS = noc_params::idx_width(PN);
    localparam int VS = noc_params::idx_width(VN);
`ifdef VC_ALLOC_PERF_EN
    localparam int CW = 16;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rr_vc_allocator_if #(
        .PORT_NUM (PN),
        .VC_NUM   (VN)
`ifdef VC_ALLOC_PERF_EN
        , .CNT_W  (CW)
`endif
    ) bus ();

    rr_vc_allocator #(
        .PORT_NUM (PN),
        .VC_NUM   (VN)
`ifdef VC_ALLOC_PERF_EN
        , .CNT_W  (CW)
`endif
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ------------------------------------------------------------ bookkeeping
    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // -------------------------------------------------------------- stimulus
    bit req  [PN][VN];
    int tgt  [PN][VN];
    bit idle [PN][VN];

    task automatic clear_stim();
        for (int p = 0; p < PN; p++)
            for (int v = 0; v < VN; v++) begin
                req[p][v]  = 1'b0;
                tgt[p][v]  = 0;
                idle[p][v] = 1'b0;
            end
    endtask

    task automatic drive();
        for (int p = 0; p < PN; p++)
            for (int v = 0; v < VN; v++) begin
                bus.vc_request_i[p*VN+v]            = req[p][v];
                bus.out_port_i[(p*VN+v)*PS +: PS]   = PS'(tgt[p][v]);
                bus.idle_downstream_vc_i[p*VN+v]    = idle[p][v];
            end
    endtask

    // ---------------------------------------------------------- reference model
    bit m_avail [PN][VN];
    int m_in    [PN];
    int m_out   [PN];
    int m_sel   [PN];
    int m_cnt   [PN];
    int s1      [PN];   // VC chosen by upstream port p, -1 if none
    int win     [PN];   // upstream port that wins downstream port d, -1 if none
    int nv      [PN];   // first free VC of downstream port d from its pointer
    logic [PN*VN-1:0] exp_valid;

    task automatic model_reset();
        for (int d = 0; d < PN; d++) begin
            for (int v = 0; v < VN; v++) m_avail[d][v] = 1'b1;
            m_in[d] = 0; m_out[d] = 0; m_sel[d] = 0; m_cnt[d] = 0;
        end
    endtask

    function automatic bit has_free(input int d);
        for (int v = 0; v < VN; v++) if (m_avail[d][v]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_eval();
        exp_valid = '0;
        for (int p = 0; p < PN; p++) begin
            s1[p] = -1;
            for (int k = 0; k < VN; k++) begin
                int v = (m_in[p] + k) % VN;
                if (s1[p] < 0 && req[p][v] && has_free(tgt[p][v])) s1[p] = v;
            end
        end
        for (int d = 0; d < PN; d++) begin
            win[d] = -1;
            nv[d]  = -1;
            for (int k = 0; k < PN; k++) begin
                int p = (m_out[d] + k) % PN;
                if (win[d] < 0 && s1[p] >= 0 && tgt[p][s1[p]] == d) win[d] = p;
            end
            for (int k = 0; k < VN; k++) begin
                int v = (m_sel[d] + k) % VN;
                if (nv[d] < 0 && m_avail[d][v]) nv[d] = v;
            end
            if (win[d] >= 0) exp_valid[win[d]*VN + s1[win[d]]] = 1'b1;
        end
    endtask

    task automatic model_commit();
        bit rel [PN][VN];
        for (int d = 0; d < PN; d++)
            for (int v = 0; v < VN; v++) rel[d][v] = !m_avail[d][v] && idle[d][v];
        for (int d = 0; d < PN; d++) begin
            if (win[d] >= 0) begin
                m_avail[d][nv[d]] = 1'b0;
                m_sel[d]          = (nv[d] + 1) % VN;
                m_out[d]          = (win[d] + 1) % PN;
                m_in[win[d]]      = (s1[win[d]] + 1) % VN;
                if (m_cnt[d] < 65535) m_cnt[d]++;
            end
        end
        for (int d = 0; d < PN; d++)
            for (int v = 0; v < VN; v++) if (rel[d][v]) m_avail[d][v] = 1'b1;
    endtask

    // -------------------------------------------------------------- one cycle
    // Entered just after a rising edge. Drives inputs, checks outputs on the
    // falling edge, then advances the model past the next rising edge.
    task automatic step(input bit use_want, input logic [PN*VN-1:0] want);
        drive();
        @(negedge clk);
        if (rst) begin
            check("valid_in_reset", 64'(bus.vc_valid_o), 64'(0));
        end else begin
            model_eval();
            check("vc_valid", 64'(bus.vc_valid_o), 64'(exp_valid));
            if (use_want) check("directed_valid", 64'(bus.vc_valid_o), 64'(want));
            for (int d = 0; d < PN; d++)
                if (win[d] >= 0)
                    check($sformatf("vc_new[%0d][%0d]", win[d], s1[win[d]]),
                          64'(bus.vc_new_o[(win[d]*VN + s1[win[d]])*VS +: VS]), 64'(nv[d]));
        end
`ifdef VC_ALLOC_PERF_EN
        for (int d = 0; d < PN; d++)
            check($sformatf("grant_cnt[%0d]", d), 64'(bus.grant_cnt_o[d*CW +: CW]), 64'(m_cnt[d]));
`endif
        @(posedge clk);
        #1;
        if (rst) model_reset();
        else     model_commit();
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        for (int p = 0; p < PN; p++) begin
            req[p][0] = 1'b1;
            tgt[p][0] = p;
        end
        step(1'b0, '0);
        rst = 1'b0;
        clear_stim();
    endtask

    // ----------------------------------------------------------------- main
    initial begin
        clear_stim();
        model_reset();
        rst = 1'b1;
        drive();
        @(posedge clk);
        #1;
        reset_dut();

        // First grant to port 2 takes VC0, the next takes VC1, then the port is exhausted.
        req[0][0] = 1'b1; tgt[0][0] = 2;
        step(1'b1, 10'b00_0000_0001);
        clear_stim();
        req[1][0] = 1'b1; tgt[1][0] = 2;
        step(1'b1, 10'b00_0000_0100);
        clear_stim();
        req[3][0] = 1'b1; tgt[3][0] = 2;
        step(1'b1, 10'b00_0000_0000);
        idle[2][0] = 1'b1;                       // released now, grantable next cycle
        step(1'b1, 10'b00_0000_0000);
        idle[2][0] = 1'b0;
        step(1'b1, 10'b00_0100_0000);

        // Ports 0, 1 and 3 contend for port 4 while its VCs keep draining.
        clear_stim();
        foreach (req[p]) begin
            if (p == 0 || p == 1 || p == 3) begin
                req[p][0] = 1'b1; tgt[p][0] = 4;
            end
        end
        idle[4][0] = 1'b1; idle[4][1] = 1'b1;
        step(1'b1, 10'b00_0000_0001);
        step(1'b1, 10'b00_0000_0100);
        step(1'b1, 10'b00_0100_0000);

        // Two VCs of upstream port 0 alternate.
        reset_dut();
        req[0][0] = 1'b1; tgt[0][0] = 0;
        req[0][1] = 1'b1; tgt[0][1] = 1;
        for (int d = 0; d < PN; d++) begin idle[d][0] = 1'b1; idle[d][1] = 1'b1; end
        step(1'b1, 10'b00_0000_0001);
        step(1'b1, 10'b00_0000_0010);
        step(1'b1, 10'b00_0000_0001);

        // Grant and release on distinct VCs of port 3 in the same cycle.
        reset_dut();
        req[4][0] = 1'b1; tgt[4][0] = 3;
        step(1'b1, 10'b01_0000_0000);            // takes VC0
        idle[3][0] = 1'b1;
        step(1'b1, 10'b01_0000_0000);            // takes VC1, VC0 released
        clear_stim();
        req[2][0] = 1'b1; tgt[2][0] = 3;
        step(1'b1, 10'b00_0001_0000);            // VC0 again
        step(1'b1, 10'b00_0000_0000);            // port 3 exhausted

        // Randomized traffic with occasional reset pulses.
        for (int n = 0; n < 3000; n++) begin
            for (int p = 0; p < PN; p++)
                for (int v = 0; v < VN; v++) begin
                    req[p][v]  = ($urandom_range(0, 1) == 1);
                    tgt[p][v]  = int'($urandom_range(0, PN-1));
                    idle[p][v] = ($urandom_range(0, 3) == 0);
                end
            rst = ($urandom_range(0, 199) == 0);
            step(1'b0, '0);
        end
        rst = 1'b0;

`ifdef VC_ALLOC_PERF_EN
        // Counter saturation: continuous grants to port 1.
        reset_dut();
        req[0][0] = 1'b1; tgt[0][0] = 1;
        idle[1][0] = 1'b1; idle[1][1] = 1'b1;
        for (int n = 0; n < 70000; n++) step(1'b0, '0);
        @(negedge clk);
        check("grant_cnt_sat", 64'(bus.grant_cnt_o[1*CW +: CW]), 64'(65535));
        @(posedge clk);
        #1;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
